// File: rtl/dmem_responder.sv
// Data-memory responder: one valid/ready load/store at a time, fixed LATENCY busy cycles, held response.
// Optional DMEM_ALIGN_CHECK_EN: misaligned byte addresses are rejected as errors.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        write_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          err;
    logic          commit;

    // Any word-index bit above the memory size makes the access out of range.
    always_comb begin
        idx = addr_q[AW+2:3];
        err = |addr_q[63:AW+3];
`ifdef DMEM_ALIGN_CHECK_EN
        err = err | (|addr_q[2:0]);
`endif
        commit = (state == BUSY) && (cnt == '0);
    end

`ifndef DMEM_ALIGN_CHECK_EN
    logic unused_low_bits;
    assign unused_low_bits = ^addr_q[2:0];
`endif

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // Memory has no reset; reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (commit && write_q && !err && !reset)
            mem[idx] <= wdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        cnt       <= 4'(LATENCY - 1);
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        rsp_err   <= err;
                        rsp_rdata <= (err || write_q) ? '0 : mem[idx];
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: expected responses queued at request time, checked on response.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model [DEPTH];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request at a negedge; returns at the negedge following the accept edge.
    task automatic do_req(input logic wr, input logic [63:0] addr, input logic [63:0] wdata, input bit track);
        logic [60:0] widx;
        logic        e;
        exp_t        x;
        @(negedge clk);
        check("req_ready_before_req", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        if (track) begin
            widx = addr[63:3];
            e    = (widx >= 61'(DEPTH));
`ifdef DMEM_ALIGN_CHECK_EN
            e    = e || (addr[2:0] != 3'd0);
`endif
            x.err   = e;
            x.rdata = '0;
            if (!e) begin
                if (wr) model[widx[7:0]] = wdata;
                else    x.rdata = model[widx[7:0]];
            end
            sb.push_back(x);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Expects rsp_valid exactly LAT edges after accept, then compares against the scoreboard head.
    task automatic get_rsp(input bit release_rsp);
        exp_t x;
        for (int i = 0; i < LAT; i++) begin
            check("rsp_valid_low_busy", {63'd0, rsp_valid}, 64'd0);
            check("req_ready_low_busy", {63'd0, req_ready}, 64'd0);
            @(negedge clk);
        end
        check("rsp_valid_at_latency", {63'd0, rsp_valid}, 64'd1);
        check("scoreboard_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            x = sb.pop_front();
            check("rsp_rdata", rsp_rdata, x.rdata);
            check("rsp_err", {63'd0, rsp_err}, {63'd0, x.err});
        end
        if (release_rsp) begin
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check("rsp_valid_after_ack", {63'd0, rsp_valid}, 64'd0);
            check("req_ready_after_ack", {63'd0, req_ready}, 64'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] held;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_req_ready", {63'd0, req_ready}, 64'd1);
        check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("reset_rsp_rdata", rsp_rdata, 64'd0);
        check("reset_rsp_err", {63'd0, rsp_err}, 64'd0);

        // Seed words 0, 1 and 3 with known values.
        do_req(1'b1, 64'h0,  64'hA5A5_0000_1111_2222, 1'b1); get_rsp(1'b1);
        do_req(1'b1, 64'h8,  64'h0808_0808_0808_0808, 1'b1); get_rsp(1'b1);
        do_req(1'b1, 64'h18, 64'h0000_0000_0000_0C0C, 1'b1); get_rsp(1'b1);

        // Store then load same address.
        do_req(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 1'b1); get_rsp(1'b1);
        do_req(1'b0, 64'h10, 64'h0, 1'b1);                 get_rsp(1'b1);

        // Response backpressure with a competing request offered.
        do_req(1'b0, 64'h10, 64'h0, 1'b1);
        get_rsp(1'b0);
        held = rsp_rdata;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 64'h0;
            req_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
            @(negedge clk);
            check("bp_rsp_valid_held", {63'd0, rsp_valid}, 64'd1);
            check("bp_rsp_rdata_held", rsp_rdata, 64'hDEADBEEF_CAFEF00D);
            check("bp_req_ready_low", {63'd0, req_ready}, 64'd0);
        end
        check("bp_rdata_stable", rsp_rdata, held);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_rsp_valid_fall", {63'd0, rsp_valid}, 64'd0);
        check("bp_req_ready_rise", {63'd0, req_ready}, 64'd1);

        // Out-of-range store, then word 0 must be untouched (also proves the backpressured store was dropped).
        do_req(1'b1, 64'h800, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1); get_rsp(1'b1);
        do_req(1'b0, 64'h0, 64'h0, 1'b1);                     get_rsp(1'b1);

        // Reset one cycle after accept aborts the store.
        do_req(1'b1, 64'h18, 64'h1234, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            check("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
            @(negedge clk);
        end
        check("abort_req_ready", {63'd0, req_ready}, 64'd1);
        do_req(1'b0, 64'h18, 64'h0, 1'b1); get_rsp(1'b1);

        // Misaligned load: error with the alignment check, word 1 without it.
        do_req(1'b0, 64'h0C, 64'h0, 1'b1); get_rsp(1'b1);

        // Back-to-back: next request accepted right after the ack cycle.
        do_req(1'b0, 64'h8, 64'h0, 1'b1); get_rsp(1'b1);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the LEGv8 datapath's data-memory port. Accepts one 64-bit load or store request per transaction over a valid/ready handshake, models a fixed multi-cycle access latency, and returns read data or a store acknowledgement over a response handshake. It replaces the zero-latency data memory when the core is moved to a stall-capable (multi-cycle/pipelined) datapath. It is the responder end of the core's load/store request interface.

## Interface

- DEPTH_WORDS, 256: number of 64-bit words stored; power of two, at least 2.
- LATENCY, 2: BUSY cycles per access; range 1..15.

- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  64  byte address.
- req_wdata  input  64  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  64  load data; 0 for stores and errors.
- rsp_err  output  1  request rejected; no memory side effect.

## Operation

- States: IDLE, BUSY, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, the block latches write, addr, and wdata into a request register; latency counter := LATENCY-1; state goes to BUSY.
- BUSY: req_ready=0. The counter decrements each cycle. When the counter is 0, the access commits:
  - Error check: word index = req_addr[63:3]. An error is flagged if the index is >= DEPTH_WORDS.
  - Store with no error: mem[index] := wdata.
  - Load with no error: rsp_rdata := mem[index].
  - Error: no write; rsp_rdata := 0; rsp_err := 1.
  - State goes to RESP.
- RESP: rsp_valid=1, with rsp_rdata and rsp_err held stable. On rsp_ready=1, state goes to IDLE. The response stays held for as long as rsp_ready=0.
- Only one transaction is outstanding at a time. req_ready is low throughout BUSY and RESP, and requests offered then are not accepted.
- Reset:
  - State := IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 in the cycle after reset deasserts.
  - Memory contents are not cleared by reset.
  - Reset asserted during BUSY before the commit edge aborts the transaction. A pending store is not written.
  - Reset asserted during RESP drops the response.
- Memory contents are undefined until written. The bench writes before reading.

## Timing

- Accept edge is E0, the edge where req_valid&&req_ready.
- Commit edge is E0+LATENCY.
- rsp_valid goes high in the cycle after the commit edge. Load-to-response latency is therefore LATENCY+1 cycles from acceptance.
- rsp_valid falls the cycle after the edge where rsp_ready is sampled high.
- req_ready rises in that same cycle. Back-to-back throughput is one transaction per LATENCY+2 cycles with rsp_ready tied high.
- Combinational paths:
  - req_ready and rsp_valid are decoded from the state register only.
  - No input-to-output combinational path exists.
- A store followed by a load to the same address returns the new data. The store commits before the load is accepted.

## Configuration

- DMEM_ALIGN_CHECK_EN defined:
  - req_addr[2:0]!=0 is also an error: rsp_err=1, no write, rsp_rdata=0.
  - Timing is unchanged.
- Not defined: req_addr[2:0] is ignored, and the access goes to word req_addr[63:3].

## Test plan

- Reset, then check idle outputs: after reset high for 2 cycles then low -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Store then load, LATENCY=2:
  - Store addr 0x10, data 0xDEADBEEF_CAFEF00D -> rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
  - Then load addr 0x10 -> rsp_rdata=0xDEADBEEF_CAFEF00D, 3 cycles after accept.
- Response backpressure: load with rsp_ready=0 held for 5 cycles -> rsp_valid and rsp_rdata held stable, req_ready=0, and a second req_valid is not accepted. Raising rsp_ready -> rsp_valid low and req_ready high the next cycle.
- Out-of-range store, DEPTH_WORDS=256: store to addr 0x800 (word 256) -> rsp_err=1. A load of addr 0x0 then returns its prior value, showing no aliasing.
- Reset mid-store: store addr 0x18, data 0x1234, and assert reset 1 cycle after accept -> no response. A later load of 0x18 returns the old value.
- Misaligned address 0x0C:
  - With DMEM_ALIGN_CHECK_EN -> rsp_err=1.
  - Without it -> the access goes to word 1 (address 0x08) with rsp_err=0.
